// File: rtl/borrow_select_subtractor_pkg.sv
// Shared types and helpers for the nibble-serial borrow-select subtractor.
package borrow_select_subtractor_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed overflow: operands of opposite sign and the result sign left the minuend's.
  function automatic logic ovf_flag(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/borrow_select_subtractor_if.sv
// Operand/result valid-ready bundle for the subtractor.
interface borrow_select_subtractor_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, ovf
  );
endinterface

// File: rtl/borrow_select_slice.sv
// Combinational 4-bit borrow-select slice: two ripple chains (carry-in 1 / 0)
// with the incoming borrow picking one, like a carry-select adder stage.
module borrow_select_slice
  import borrow_select_subtractor_pkg::*;
(
  input  logic [SLICE_W-1:0] a_nib,
  input  logic [SLICE_W-1:0] b_nib,
  input  logic               bsel,
  output logic [SLICE_W-1:0] d_nib,
  output logic               bout_nib
);
  logic [SLICE_W-1:0] nb, s1, s0;
  logic               c1, c0;

  assign nb = ~b_nib;

  always_comb begin
    s1 = '0;
    s0 = '0;
    c1 = 1'b1;
    c0 = 1'b0;
    for (int i = 0; i < SLICE_W; i++) begin
      s1[i] = a_nib[i] ^ nb[i] ^ c1;
      c1    = (a_nib[i] & nb[i]) | (c1 & (a_nib[i] ^ nb[i]));
      s0[i] = a_nib[i] ^ nb[i] ^ c0;
      c0    = (a_nib[i] & nb[i]) | (c0 & (a_nib[i] ^ nb[i]));
    end
  end

  // Borrow is the inverted carry of the selected chain.
  assign d_nib    = bsel ? s0 : s1;
  assign bout_nib = bsel ? ~c0 : ~c1;
endmodule

// File: rtl/borrow_select_subtractor.sv
// Nibble-serial subtractor: one shared borrow-select slice walks the operand
// LSB-first, one nibble per clock, behind valid/ready handshakes.
module borrow_select_subtractor
  import borrow_select_subtractor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                    clk,
  input logic                    rst,
  borrow_select_subtractor_if.slave bus
);
  localparam int N     = WIDTH / SLICE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, diff_q, diff_nxt;
  logic [IDX_W-1:0]   idx;
  logic               brw, bout_q, zero_q, ovf_q;
  logic [SLICE_W-1:0] d_nib;
  logic               bout_nib;
  logic               accept, last;

  assign accept = (state_q == IDLE) && bus.in_valid;
  assign last   = (state_q == RUN) && (idx == LAST);

  borrow_select_slice u_slice (
    .a_nib    (a_q[idx*SLICE_W +: SLICE_W]),
    .b_nib    (b_q[idx*SLICE_W +: SLICE_W]),
    .bsel     (brw),
    .d_nib    (d_nib),
    .bout_nib (bout_nib)
  );

  // Full result including the nibble being produced this cycle, so the flags
  // can be taken on the final RUN edge.
  always_comb begin
    diff_nxt = diff_q;
    diff_nxt[idx*SLICE_W +: SLICE_W] = d_nib;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (idx == LAST)   state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      idx    <= '0;
      brw    <= 1'b0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_q <= bus.a;
      b_q <= bus.b;
      brw <= bus.bin;
      idx <= '0;
    end else if (state_q == RUN) begin
      diff_q <= diff_nxt;
      brw    <= bout_nib;
      idx    <= last ? '0 : idx + IDX_W'(1);
      if (last) begin
        bout_q <= bout_nib;
        zero_q <= (diff_nxt == '0);
        ovf_q  <= ovf_flag(a_q[WIDTH-1], b_q[WIDTH-1], diff_nxt[WIDTH-1]);
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_borrow_select_subtractor.sv
// Self-checking bench: directed corner cases plus random operands against an
// arithmetic reference model.
module tb_borrow_select_subtractor;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  borrow_select_subtractor_if #(.WIDTH(WIDTH)) bus();

  borrow_select_subtractor #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin,
                       output logic [15:0] ed, output logic eb, output logic ez, output logic eo);
    int r, sr;
    r  = int'(ma) - int'(mb) - int'(mbin);
    sr = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    ed = r[15:0];
    eb = (r < 0);
    ez = (ed == 16'h0000);
    eo = (sr < -32768) || (sr > 32767);
  endtask

  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin);
    chk("in_ready_idle", bus.in_ready, 1);
    bus.a = ta; bus.b = tb_; bus.bin = tbin; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom); bus.b = 16'($urandom); bus.bin = 1'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.out_valid && lat < 20);
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin, input int hold);
    logic [15:0] ed; logic eb, ez, eo;
    int lat;
    model(ta, tb_, tbin, ed, eb, ez, eo);
    start_op(ta, tb_, tbin);
    wait_done(lat);
    chk("latency", lat, 4);
    chk("diff", bus.diff, ed);
    chk("bout", bus.bout, eb);
    chk("zero", bus.zero, ez);
    chk("ovf",  bus.ovf,  eo);
    repeat (hold) begin @(posedge clk); #1; end
    chk("diff_hold", bus.diff, ed);
    chk("out_valid_hold", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("in_ready_after", bus.in_ready, 1);
    chk("out_valid_after", bus.out_valid, 0);
  endtask

  initial begin
    int lat, seen;
    logic [15:0] ed; logic eb, ez, eo;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    #12 rst = 1'b0;
    @(posedge clk); #1;

    // Leave a result parked in DONE, then reset mid-cycle.
    start_op(16'h1234, 16'h0234, 1'b0);
    wait_done(lat);
    chk("pre_reset_valid", bus.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_diff", bus.diff, 16'h0000);
    chk("rst_flags", {bus.bout, bus.zero, bus.ovf}, 3'b000);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    run_op(16'h1234, 16'h0234, 1'b0, 0);
    run_op(16'h0000, 16'h0001, 1'b0, 1);
    run_op(16'h0005, 16'h0004, 1'b1, 0);
    run_op(16'h8000, 16'h0001, 1'b0, 0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 2);

    // Backpressure: new operands pulsed while DONE is stalled are not captured.
    model(16'h4321, 16'h0321, 1'b0, ed, eb, ez, eo);
    start_op(16'h4321, 16'h0321, 1'b0);
    wait_done(lat);
    for (int i = 0; i < 3; i++) begin
      bus.a = 16'hAAAA; bus.b = 16'h1111; bus.bin = 1'b1; bus.in_valid = 1'(i % 2 == 0);
      @(posedge clk); #1;
      chk("bp_diff", bus.diff, ed);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_out_valid", bus.out_valid, 1);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_release_in_ready", bus.in_ready, 1);
    chk("bp_no_capture", bus.out_valid, 0);
    @(posedge clk); #1;
    chk("bp_still_idle", bus.in_ready, 1);

    // Abort while the slice index is 2.
    start_op(16'h5555, 16'h1111, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_diff", bus.diff, 16'h0000);
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (bus.out_valid) seen++; end
    chk("abort_no_valid", seen, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);

    for (int k = 0; k < 40; k++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/borrow_select_subtractor.md
# borrow_select_subtractor

Multi-cycle, nibble-serial subtractor: the inverse arithmetic companion to the 4-bit carry-select adder. It computes a WIDTH-bit difference one 4-bit borrow-select slice per clock. Inputs and outputs use valid/ready handshakes, so the block sits between an operand source and a result sink in the arithmetic datapath. Flags report borrow, zero and signed overflow.

## Interface
Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result present (high only in DONE).
- out_ready  input  1  sink accepts result.
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
- bout  output  1  unsigned borrow-out: 1 when a < b + bin.
- zero  output  1  diff == 0.
- ovf  output  1  two's-complement overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).

## Operation
- States: IDLE, RUN, DONE. Let N = WIDTH/4.
- IDLE:
  - in_ready = 1.
  - When in_valid && in_ready at an edge: register a, b, set borrow register = bin, clear slice index to 0, go to RUN.
  - Later changes on a, b or bin are ignored.
- RUN:
  - Each cycle the slice at index i processes bits [4i+3:4i].
  - The slice computes two candidates: a_i + ~b_i + 1 (borrow-in 0) and a_i + ~b_i + 0 (borrow-in 1).
  - The registered borrow selects between them. The result nibble is written into diff bits [4i+3:4i], and the borrow register takes the selected slice borrow-out.
  - The slice borrow-out is the inverse of the carry-out.
  - After index N-1: compute bout, zero and ovf from the final values, go to DONE.
- DONE:
  - out_valid = 1.
  - diff, bout, zero and ovf are held stable until out_ready.
  - On out_valid && out_ready: go to IDLE.
- in_valid is ignored outside IDLE. There is no input/output overlap and no bypass.
- Reset values: state IDLE, in_ready 1, out_valid 0, diff 0, bout 0, zero 0, ovf 0, index 0, borrow register 0.
- Reset mid-operation (RUN or DONE) aborts immediately. The transaction is lost and no partial result is emitted.
- The slice index wraps only through state exit and never exceeds N-1.

## Timing
- Accept edge at cycle 0. RUN occupies cycles 1..N. out_valid rises after edge N, so it is visible N cycles after acceptance (4 for WIDTH=16).
- The earliest the next acceptance can occur is the cycle after the output handshake. in_ready rises the cycle after out_valid && out_ready.
- Throughput: one result per N+2 cycles with out_ready held high.
- All outputs are registered; no combinational path runs from inputs to outputs.
- in_ready and out_valid are decoded from state only.

## Structure
- Shared package holds:
  - SLICE_W = 4;
  - the state enum {IDLE, RUN, DONE};
  - a helper that computes the ovf flag.
- One sub-module, borrow_select_slice:
  - combinational, 4-bit;
  - inputs a_nib, b_nib, bsel;
  - outputs d_nib, bout_nib.
  - Internally it uses two ripple chains with carry-in 1 and 0 plus a 2:1 select on bsel, mirroring the carry-select structure.
- Top level holds the FSM, operand registers, slice index counter, borrow register and result register. It instantiates one slice, time-multiplexed over nibbles.

## Test plan
All scenarios use WIDTH=16.
- Reset: assert rst asynchronously mid-cycle -> in_ready 1, out_valid 0, diff 0x0000 and all flags 0 without waiting for a clock edge.
- Basic: a=0x1234, b=0x0234, bin=0 -> out_valid exactly 4 cycles after accept; diff 0x1000, bout 0, zero 0, ovf 0.
- Borrow chain: a=0x0000, b=0x0001, bin=0 -> diff 0xFFFF, bout 1, ovf 0. Also a=0x0005, b=0x0004, bin=1 -> diff 0x0000, zero 1, bout 0.
- Signed overflow: a=0x8000, b=0x0001, bin=0 -> diff 0x7FFF, ovf 1, bout 0. Also a=0x7FFF, b=0xFFFF -> diff 0x8000, ovf 1, bout 1.
- Backpressure: hold out_ready low for 3 cycles in DONE while pulsing in_valid with new operands -> outputs unchanged, in_ready 0, new operands not captured. Raise out_ready -> in_ready 1 on the next cycle.
- Abort: assert rst while the slice index is 2 -> outputs return to reset values and no out_valid occurs. After release, a=0xFFFF, b=0x0001 -> diff 0xFFFE, bout 0.
